// File: rtl/pwm_pkg.sv
// Shared register map constants and address helpers for the PWM controller.
package pwm_pkg;
  localparam int PWM_ADDR_W = 5;
  localparam int PWM_DATA_W = 32;

  localparam logic [PWM_ADDR_W-1:0] PWM_REG_CTRL     = 5'd0;
  localparam logic [PWM_ADDR_W-1:0] PWM_REG_PRESCALE = 5'd1;
  localparam logic [PWM_ADDR_W-1:0] PWM_REG_CH_BASE  = 5'd2;
  localparam int                    PWM_CH_STRIDE    = 2;

  function automatic logic [PWM_ADDR_W-1:0] pwm_top_idx(input int n);
    return PWM_ADDR_W'(int'(PWM_REG_CH_BASE) + PWM_CH_STRIDE * n);
  endfunction

  function automatic logic [PWM_ADDR_W-1:0] pwm_cmp_idx(input int n);
    return PWM_ADDR_W'(int'(PWM_REG_CH_BASE) + PWM_CH_STRIDE * n + 1);
  endfunction
endpackage

// File: rtl/pwm_controller_if.sv
// Single-cycle configuration register port of the PWM controller.
interface pwm_controller_if;
  import pwm_pkg::*;

  logic [PWM_ADDR_W-1:0] cfg_addr;
  logic [PWM_DATA_W-1:0] cfg_wdata;
  logic                  cfg_we;
  logic                  cfg_re;
  logic [PWM_DATA_W-1:0] cfg_rdata;

  modport master (output cfg_addr, cfg_wdata, cfg_we, cfg_re, input cfg_rdata);
  modport slave  (input cfg_addr, cfg_wdata, cfg_we, cfg_re, output cfg_rdata);
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: period counter, double-buffered TOP/COMPARE and output flop.
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic [WIDTH-1:0] top_shadow,
  input  logic [WIDTH-1:0] compare_shadow,
  output logic             pwm_out
);
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH-1:0] r_cmp;
  logic             r_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_top <= '0;
      r_cmp <= '0;
      r_out <= 1'b0;
    end else if (!enable) begin
      // Idle channel tracks the shadows so a later enable starts from fresh values.
      r_cnt <= '0;
      r_top <= top_shadow;
      r_cmp <= compare_shadow;
      r_out <= 1'b0;
    end else begin
      r_out <= (r_cnt < r_cmp);
      if (tick) begin
        if (r_cnt == r_top) begin
          r_cnt <= '0;
          r_top <= top_shadow;
          r_cmp <= compare_shadow;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign pwm_out = r_out;
endmodule

// File: rtl/pwm_controller.sv
// Eight-channel PWM peripheral: register file, shared prescaler and channel array.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  pwm_controller_if.slave     bus,
  output logic [CHANNELS-1:0] pwm_en,
  output logic [CHANNELS-1:0] pwm_out
);
  logic [CHANNELS-1:0]   r_ctrl;
  logic [CHANNELS-1:0]   w_ctrl_next;
  logic [CHANNELS-1:0]   w_ch_en;
  logic [WIDTH-1:0]      r_prescale;
  logic [WIDTH-1:0]      r_pre_cnt;
  logic [WIDTH-1:0]      r_top      [CHANNELS];
  logic [WIDTH-1:0]      r_cmp      [CHANNELS];
  logic [WIDTH-1:0]      w_top_next [CHANNELS];
  logic [WIDTH-1:0]      w_cmp_next [CHANNELS];
  logic [PWM_DATA_W-1:0] r_rdata;
  logic [PWM_DATA_W-1:0] w_rdata;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_wr_prescale;
  logic                  w_unused;

  assign w_unused = ^bus.cfg_wdata[PWM_DATA_W-1:WIDTH];

  // Next shadow values include this cycle's write, so a write on the wrap tick is captured.
  always_comb begin
    w_ctrl_next = r_ctrl;
    if (bus.cfg_we && bus.cfg_addr == PWM_REG_CTRL)
      w_ctrl_next = bus.cfg_wdata[CHANNELS-1:0];
    for (int n = 0; n < CHANNELS; n++) begin
      w_top_next[n] = r_top[n];
      w_cmp_next[n] = r_cmp[n];
      if (bus.cfg_we && bus.cfg_addr == pwm_top_idx(n))
        w_top_next[n] = bus.cfg_wdata[WIDTH-1:0];
      if (bus.cfg_we && bus.cfg_addr == pwm_cmp_idx(n))
        w_cmp_next[n] = bus.cfg_wdata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.cfg_addr == PWM_REG_CTRL)
      w_rdata = PWM_DATA_W'(r_ctrl);
    else if (bus.cfg_addr == PWM_REG_PRESCALE)
      w_rdata = PWM_DATA_W'(r_prescale);
    for (int n = 0; n < CHANNELS; n++) begin
      if (bus.cfg_addr == pwm_top_idx(n)) w_rdata = PWM_DATA_W'(r_top[n]);
      if (bus.cfg_addr == pwm_cmp_idx(n)) w_rdata = PWM_DATA_W'(r_cmp[n]);
    end
  end

  assign w_wr_prescale = bus.cfg_we && (bus.cfg_addr == PWM_REG_PRESCALE);
  assign w_run         = |r_ctrl;
  // >= keeps the prescaler bounded if PRESCALE shrinks below the running count.
  assign w_tick        = w_run && (r_pre_cnt >= r_prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_rdata    <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_top[n] <= '0;
        r_cmp[n] <= '0;
      end
    end else begin
      r_ctrl <= w_ctrl_next;
      for (int n = 0; n < CHANNELS; n++) begin
        r_top[n] <= w_top_next[n];
        r_cmp[n] <= w_cmp_next[n];
      end
      if (w_wr_prescale) r_prescale <= bus.cfg_wdata[WIDTH-1:0];
      if (!w_run || w_tick) r_pre_cnt <= '0;
      else                  r_pre_cnt <= r_pre_cnt + 1'b1;
      if (bus.cfg_re) r_rdata <= w_rdata;
    end
  end

  // A disable written this cycle stops the channel at the same edge that drops pwm_en.
  assign w_ch_en       = r_ctrl & w_ctrl_next;
  assign pwm_en        = r_ctrl;
  assign bus.cfg_rdata = r_rdata;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk            (clk),
      .rst            (rst),
      .tick           (w_tick),
      .enable         (w_ch_en[g]),
      .top_shadow     (w_top_next[g]),
      .compare_shadow (w_cmp_next[g]),
      .pwm_out        (pwm_out[g])
    );
  end
endmodule

// File: doc/pwm_controller.md
# pwm_controller

Eight-channel PWM generator peripheral. It drives the `pwm_en`/`pwm_out` inputs of the IO multiplexer, which routes each channel onto its pad when enabled. A shared prescaler drives the channels. Each channel has its own period counter, period (TOP) and duty (COMPARE) registers, and double-buffered updates at period wrap. Software configures it through a simple single-cycle register port, which the peripheral bus wrapper bridges.

## Interface
- `CHANNELS`, 8: number of PWM channels, 1..8.
- `WIDTH`, 16: counter, TOP, COMPARE and PRESCALE width.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `cfg_addr` input 5: word index of the register.
- `cfg_wdata` input 32: write data.
- `cfg_we` input 1: write strobe, one cycle per write.
- `cfg_re` input 1: read strobe.
- `cfg_rdata` output 32: read data, valid the cycle after `cfg_re`.
- `pwm_en` output CHANNELS: channel enable, to the IO multiplexer.
- `pwm_out` output CHANNELS: PWM waveform, to the IO multiplexer.

## Operation
Register map, by word index; unmapped reads return 0 and unmapped writes are ignored:
- Index 0, CTRL: bits [CHANNELS-1:0] are the channel enables.
- Index 1, PRESCALE: bits [WIDTH-1:0].
- Index 2+2n, TOP_n: shadow period register for channel n.
- Index 3+2n, COMPARE_n: shadow duty register for channel n.

Read-back returns the shadow values, zero-extended.

Prescaler:
- The counter counts 0..PRESCALE and then returns to 0.
- `tick` is high in the cycle the counter equals PRESCALE, so PRESCALE=0 gives a tick every cycle.
- It runs whenever any channel is enabled and is held at 0 when all channels are disabled.

Channel n, disabled:
- `cnt`=0.
- Active TOP/COMPARE are copied from the shadow registers every cycle.
- `pwm_out[n]`=0.

Channel n, enabled:
- On `tick`: if `cnt`==active TOP, then `cnt`←0 and the active registers load from shadow. Otherwise `cnt`←`cnt`+1.
- Shadow writes made mid-period never alter the current period (double buffering).
- Next-cycle `pwm_out[n]` = (`cnt` < active COMPARE), evaluated on the registered `cnt`.
- COMPARE=0 gives constant low. COMPARE>TOP gives constant high.
- Period = (TOP+1)·(PRESCALE+1) clocks. High time = min(COMPARE, TOP+1)·(PRESCALE+1) clocks.

`pwm_en[n]` is CTRL bit n, registered directly.

Clearing an enable bit stops the channel immediately: on the next edge `cnt`=0 and `pwm_out[n]`=0.

## Timing
Reset values:
- All registers, counters, `cfg_rdata`, `pwm_en` and `pwm_out` are 0.
- An asynchronous assert clears everything immediately, including mid-period.
- Deassertion is synchronous to `clk`; reset must be externally synchronised for release.

Register port:
- A write lands at the `clk` edge where `cfg_we`=1.
- A CTRL write changes `pwm_en` at that edge.
- `cfg_re` in cycle t gives `cfg_rdata` valid in cycle t+1. It holds its value until the next read.

Channel start:
- A CTRL enable written at edge e loads active from shadow at e. `cnt` starts counting at the first `tick` after e.
- `pwm_out` reflects `cnt` with 1-cycle latency.
- For COMPARE>0 the first high level appears at e+1.

Simultaneous events:
- A shadow write in the same cycle as the wrap `tick` is captured by the active registers; the new value wins.
- A CTRL disable in the same cycle as a `tick` makes the disable win.
- If `cfg_we` and `cfg_re` target the same address in the same cycle, `cfg_rdata` returns the old value.

Writes that shrink TOP below the current `cnt`:
- These take effect only at wrap, so `cnt` cannot pass TOP.
- A disabled-channel shadow write is picked up immediately.

## Structure
- Package `pwm_pkg` holds the register index constants (`PWM_REG_CTRL`=0, `PWM_REG_PRESCALE`=1, `PWM_REG_CH_BASE`=2) and the per-channel stride of 2.
- Sub-module `pwm_channel` holds one counter, active/shadow TOP/COMPARE and the output flop, with ports `clk`, `rst`, `tick`, `enable`, `top_shadow`, `compare_shadow`, `pwm_out`.
- The top level holds the prescaler, the register file and read mux, and a generate loop over CHANNELS.

## Test plan
- Reset mid-run: assert `rst` low while channels are toggling → all outputs and `cfg_rdata` are 0 immediately. After release, CTRL reads 0.
- PRESCALE=0, TOP_0=3, COMPARE_0=2, CTRL=1 → `pwm_en[0]`=1 at the write edge. `pwm_out[0]` repeats 1,1,0,0 with period 4 starting at e+1.
- PRESCALE=2, TOP_1=1, COMPARE_1=1 → period 6 clocks, high 3 clocks. A read of index 1 returns 2 the next cycle.
- Duty boundaries on channel 2, TOP=4:
  - COMPARE=0 → constant 0.
  - COMPARE=5 → constant 1.
  - COMPARE=7 → constant 1.
- Double buffering on channel 0 (TOP=7, COMPARE=4): write COMPARE=2 at `cnt`=1 → the current period keeps 4 high clocks and the next period has 2. A write landing on the wrap tick applies to that wrap.
- Disable: clear CTRL bit 3 mid-period → next edge gives `pwm_out[3]`=0 and `pwm_en[3]`=0. Re-enable restarts from `cnt`=0, and other channels are undisturbed.
